// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target: FSM states, bit-counter
// width and the 8-bit bus addresses derived from the 7-bit device ID.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_MACK,
    ST_IGNORE
  } sccb_state_e;

  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = 4'd8;

  function automatic logic [7:0] sccb_wr_id(input logic [6:0] dev_id);
    return {dev_id, 1'b0};
  endfunction

  function automatic logic [7:0] sccb_rd_id(input logic [6:0] dev_id);
    return {dev_id, 1'b1};
  endfunction

endpackage

// File: rtl/sccb_sync_edge.sv
// Synchronizes the SCCB pad lines and turns them into registered one-cycle
// event pulses: SCL rise/fall plus START/STOP conditions.
module sccb_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_smp
);

  logic [1:0] r_scl_s, r_sda_s;
  logic       r_scl_h, r_sda_h;
  logic       w_scl, w_sda;

  assign w_scl = r_scl_s[1];
  assign w_sda = r_sda_s[1];

  // SDA edges qualify against the new SCL value, so a coincident change is
  // treated as SCL moving first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_s   <= 2'b11;
      r_sda_s   <= 2'b11;
      r_scl_h   <= 1'b1;
      r_sda_h   <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_smp   <= 1'b1;
    end else begin
      r_scl_s   <= {r_scl_s[0], scl_i};
      r_sda_s   <= {r_sda_s[0], sda_i};
      r_scl_h   <= w_scl;
      r_sda_h   <= w_sda;
      scl_rise  <= w_scl & ~r_scl_h;
      scl_fall  <= ~w_scl & r_scl_h;
      start_det <= r_sda_h & ~w_sda & w_scl;
      stop_det  <= ~r_sda_h & w_sda & w_scl;
      sda_smp   <= r_sda_h;
    end
  end

endmodule

// File: rtl/sccb_target.sv
// SCCB camera-side responder: decodes write/read cycles for DEV_ID, drives
// ACK and read data open-drain, and talks to a register bank via strobes.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ID     = 7'h3C,
  parameter int         ADDR_BYTES = 2,
  parameter bit         ACK_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_drive_low,
  output logic [8*ADDR_BYTES-1:0] reg_addr,
  output logic [7:0]              reg_wdata,
  output logic                    reg_we,
  output logic                    reg_re,
  input  logic [7:0]              reg_rdata,
  output logic                    busy
);

  localparam logic [7:0] SCCB_WR_ID = sccb_wr_id(DEV_ID);
  localparam logic [7:0] SCCB_RD_ID = sccb_rd_id(DEV_ID);
  localparam logic [1:0] LAST_SUB   = 2'(ADDR_BYTES - 1);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
  logic [7:0] w_byte;

  sccb_state_e            r_state;
  logic [BIT_CNT_W-1:0]   r_bitcnt;
  logic [7:0]             r_shift;
  logic [1:0]             r_sub_idx;
  logic                   r_rw, r_mack, r_re_d;
  logic                   r_drive, r_we, r_re, r_busy;
  logic [8*ADDR_BYTES-1:0] r_reg_addr;
  logic [7:0]             r_wdata;

  sccb_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start_det(w_start),
    .stop_det (w_stop),
    .sda_smp  (w_sda)
  );

  assign w_byte        = {r_shift[6:0], w_sda};
  assign sda_drive_low = r_drive;
  assign reg_addr      = r_reg_addr;
  assign reg_wdata     = r_wdata;
  assign reg_we        = r_we;
  assign reg_re        = r_re;
  assign busy          = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_sub_idx  <= '0;
      r_rw       <= 1'b0;
      r_mack     <= 1'b0;
      r_re_d     <= 1'b0;
      r_drive    <= 1'b0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_busy     <= 1'b0;
      r_reg_addr <= '0;
      r_wdata    <= '0;
    end else begin
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_re_d <= r_re;
      // Register bank answers one cycle after the read strobe.
      if (r_re_d) r_shift <= reg_rdata;
      if (w_start) begin
        r_state  <= ST_DEV;
        r_bitcnt <= '0;
        r_drive  <= 1'b0;
        r_mack   <= 1'b0;
      end else if (w_stop) begin
        r_state <= ST_IDLE;
        r_drive <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_DEV: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 1'b1;
            end else if (w_scl_fall && r_bitcnt == BYTE_BITS) begin
              r_bitcnt <= '0;
              if (r_shift == SCCB_WR_ID || r_shift == SCCB_RD_ID) begin
                r_state <= ST_DEV_ACK;
                r_rw    <= r_shift[0];
                r_busy  <= 1'b1;
                r_drive <= ACK_EN;
              end else begin
                r_state <= ST_IGNORE;
                r_busy  <= 1'b0;
              end
            end
          end
          ST_DEV_ACK: begin
            if (w_scl_rise && r_rw) r_re <= 1'b1;
            if (w_scl_fall) begin
              if (r_rw) begin
                r_state  <= ST_RDATA;
                r_drive  <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_bitcnt <= 4'd1;
              end else begin
                r_state   <= ST_SUB;
                r_drive   <= 1'b0;
                r_sub_idx <= '0;
                r_bitcnt  <= '0;
              end
            end
          end
          ST_SUB: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 1'b1;
            end else if (w_scl_fall && r_bitcnt == BYTE_BITS) begin
              for (int b = 0; b < ADDR_BYTES; b++)
                if (int'(r_sub_idx) == ADDR_BYTES - 1 - b) r_reg_addr[8*b +: 8] <= r_shift;
              r_state  <= ST_SUB_ACK;
              r_drive  <= ACK_EN;
              r_bitcnt <= '0;
            end
          end
          ST_SUB_ACK: begin
            if (w_scl_fall) begin
              r_drive   <= 1'b0;
              r_sub_idx <= r_sub_idx + 1'b1;
              r_state   <= (r_sub_idx == LAST_SUB) ? ST_WDATA : ST_SUB;
            end
          end
          ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 1'b1;
              if (r_bitcnt == 4'd7) begin
                r_we    <= 1'b1;
                r_wdata <= w_byte;
              end
            end else if (w_scl_fall && r_bitcnt == BYTE_BITS) begin
              r_state  <= ST_WDATA_ACK;
              r_drive  <= ACK_EN;
              r_bitcnt <= '0;
            end
          end
          ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_drive    <= 1'b0;
              r_reg_addr <= r_reg_addr + 1'b1;
              r_state    <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (w_scl_fall) begin
              if (r_bitcnt == BYTE_BITS) begin
                r_drive  <= 1'b0;
                r_state  <= ST_RD_MACK;
                r_bitcnt <= '0;
                r_mack   <= 1'b0;
              end else begin
                r_drive  <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end
          ST_RD_MACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_mack     <= 1'b1;
                r_re       <= 1'b1;
                r_reg_addr <= r_reg_addr + 1'b1;
              end else begin
                r_state <= ST_IGNORE;
              end
            end else if (w_scl_fall && r_mack) begin
              r_state  <= ST_RDATA;
              r_mack   <= 1'b0;
              r_drive  <= ~r_shift[7];
              r_shift  <= {r_shift[6:0], 1'b0};
              r_bitcnt <= 4'd1;
            end
          end
          ST_IDLE, ST_IGNORE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: bit-banged SCCB master, register-bank model
// and strobe monitor, with immediate assertions at every check.
module tb_sccb_target;

  localparam int Q = 10;
  localparam int H = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl, sda_m;
  logic        sda_drive_low, reg_we, reg_re, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata = 8'h00;
  wire         sda_bus = sda_m & ~sda_drive_low;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] we_addr_q[$];
  logic [7:0]  we_data_q[$];
  logic [15:0] re_addr_q[$];
  int          both_cnt = 0;
  bit          drv_seen = 1'b0;

  sccb_target #(.DEV_ID(7'h3C), .ADDR_BYTES(2), .ACK_EN(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .scl_i        (scl),
    .sda_i        (sda_bus),
    .sda_drive_low(sda_drive_low),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_rdata    (reg_rdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Register bank: data is a fixed function of the address, ready next cycle.
  always @(posedge clk) if (reg_re) reg_rdata <= reg_addr[7:0] + 8'h4B;

  always @(negedge clk) begin
    if (reg_we) begin
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
    end
    if (reg_re) re_addr_q.push_back(reg_addr);
    if (reg_we && reg_re) both_cnt++;
    if (sda_drive_low) drv_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wt(Q); scl = 1'b1; wt(H); scl = 1'b0; wt(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wt(Q); scl = 1'b1; wt(Q); sda_m = 1'b0; wt(Q); scl = 1'b0; wt(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wt(Q); scl = 1'b1; wt(Q); sda_m = 1'b1; wt(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wt(Q); scl = 1'b1; wt(H/2); ack = sda_bus; wt(H/2); scl = 1'b0; wt(Q);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wt(Q); scl = 1'b1; wt(H/2); b[i] = sda_bus; wt(H/2); scl = 1'b0; wt(Q);
    end
    send_bit(mack);
  endtask

  task automatic clear_mon();
    we_addr_q.delete(); we_data_q.delete(); re_addr_q.delete();
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;

    reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
    wt(4); reset = 1'b0; wt(4);
    chk("rst_drive", 32'(sda_drive_low), 0);
    chk("rst_we", 32'(reg_we), 0);
    chk("rst_re", 32'(reg_re), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(reg_addr), 0);
    chk("rst_wdata", 32'(reg_wdata), 0);

    // Single write
    clear_mon();
    bus_start();
    write_byte(8'h78, ack); chk("w1_ack_dev", 32'(ack), 0);
    write_byte(8'h30, ack); chk("w1_ack_sub0", 32'(ack), 0);
    write_byte(8'h0A, ack); chk("w1_ack_sub1", 32'(ack), 0);
    write_byte(8'h56, ack); chk("w1_ack_data", 32'(ack), 0);
    chk("w1_busy", 32'(busy), 1);
    bus_stop(); wt(Q);
    chk("w1_busy_stop", 32'(busy), 0);
    chk("w1_we_cnt", 32'(we_addr_q.size()), 1);
    chk("w1_addr", 32'(we_addr_q[0]), 32'h300A);
    chk("w1_data", 32'(we_data_q[0]), 32'h56);

    // Burst write
    clear_mon();
    bus_start();
    write_byte(8'h78, ack); write_byte(8'h30, ack); write_byte(8'h0A, ack);
    write_byte(8'h11, ack); write_byte(8'h22, ack); write_byte(8'h33, ack);
    chk("w2_ack_last", 32'(ack), 0);
    bus_stop(); wt(Q);
    chk("w2_we_cnt", 32'(we_addr_q.size()), 3);
    chk("w2_addr0", 32'(we_addr_q[0]), 32'h300A);
    chk("w2_data0", 32'(we_data_q[0]), 32'h11);
    chk("w2_addr1", 32'(we_addr_q[1]), 32'h300B);
    chk("w2_data1", 32'(we_data_q[1]), 32'h22);
    chk("w2_addr2", 32'(we_addr_q[2]), 32'h300C);
    chk("w2_data2", 32'(we_data_q[2]), 32'h33);

    // Pointer set, then read one byte with NA
    clear_mon();
    bus_start();
    write_byte(8'h78, ack); write_byte(8'h30, ack); write_byte(8'h0A, ack);
    bus_stop(); wt(Q);
    bus_start();
    write_byte(8'h79, ack); chk("r1_ack_dev", 32'(ack), 0);
    read_byte(1'b1, rb);
    chk("r1_data", 32'(rb), 32'h55);
    chk("r1_released", 32'(sda_drive_low), 0);
    chk("r1_busy", 32'(busy), 1);
    bus_stop(); wt(Q);
    chk("r1_busy_stop", 32'(busy), 0);
    chk("r1_re_cnt", 32'(re_addr_q.size()), 1);
    chk("r1_re_addr", 32'(re_addr_q[0]), 32'h300A);
    chk("r1_we_cnt", 32'(we_addr_q.size()), 0);

    // Foreign device ID is ignored until the next START
    clear_mon(); drv_seen = 1'b0;
    bus_start();
    write_byte(8'h42, ack); chk("x_ack_dev", 32'(ack), 1);
    write_byte(8'h11, ack); write_byte(8'h22, ack); write_byte(8'h33, ack);
    bus_stop(); wt(Q);
    chk("x_no_drive", 32'(drv_seen), 0);
    chk("x_we_cnt", 32'(we_addr_q.size()), 0);
    chk("x_re_cnt", 32'(re_addr_q.size()), 0);
    chk("x_busy", 32'(busy), 0);
    bus_start();
    write_byte(8'h78, ack); chk("x_next_ack", 32'(ack), 0);
    chk("x_next_busy", 32'(busy), 1);
    bus_stop(); wt(Q);

    // Repeated START after a partial sub-address
    clear_mon();
    bus_start();
    write_byte(8'h78, ack); write_byte(8'h12, ack);
    bus_start();
    write_byte(8'h79, ack); chk("rs_ack_dev", 32'(ack), 0);
    read_byte(1'b0, rb); chk("rs_data0", 32'(rb), 32'h55);
    read_byte(1'b1, rb); chk("rs_data1", 32'(rb), 32'h56);
    bus_stop(); wt(Q);
    chk("rs_re_cnt", 32'(re_addr_q.size()), 2);
    chk("rs_re_addr0", 32'(re_addr_q[0]), 32'h120A);
    chk("rs_re_addr1", 32'(re_addr_q[1]), 32'h120B);
    chk("rs_we_cnt", 32'(we_addr_q.size()), 0);

    // Reset while driving a 0 data bit (0x56 -> MSB 0)
    bus_start();
    write_byte(8'h79, ack); chk("rr_ack_dev", 32'(ack), 0);
    chk("rr_driving", 32'(sda_drive_low), 1);
    #3 reset = 1'b1;
    #1 chk("rr_async_release", 32'(sda_drive_low), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_addr", 32'(reg_addr), 0);
    wt(2); scl = 1'b1; sda_m = 1'b1; wt(2); reset = 1'b0; wt(5);
    bus_start();
    write_byte(8'h78, ack); chk("rr_next_ack", 32'(ack), 0);
    chk("rr_next_busy", 32'(busy), 1);
    bus_stop(); wt(Q);
    chk("rr_busy_stop", 32'(busy), 0);

    chk("strobe_overlap", 32'(both_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
